send_gen: RTL

//  Parametrised packet source for one switch ingress port: emits header + payload beats on a
//  sop/eop/vld write bus toward the shared-cache switch. Adds over the previous sender:
//  wr_rdy backpressure, single/continuous/counted run modes, pacing, and sequence numbering.

---
 rtl/send_pkg.sv | 49 ++++
 rtl/send_pace_timer.sv | 40 ++++
 rtl/send_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/send_pkg.sv
// send_pkg: shared widths, header field layout and enums for the packet
// sender and the matching receive checker.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 16
`endif
`ifndef PRIORITY
`define PRIORITY 4
`endif

package send_pkg;

  localparam int DEF_DATA_WIDTH      = `DATA_WIDTH;
  localparam int DEF_PORT_NUB_TOTAL  = `PORT_NUB_TOTAL;
  localparam int DEF_DATA_LENGTH_MAX = `DATA_LENGTH_MAX;
  localparam int DEF_PRIORITY        = `PRIORITY;

  localparam int W_SEL = $clog2(DEF_PORT_NUB_TOTAL);
  localparam int W_PRI = $clog2(DEF_PRIORITY);
  localparam int W_LEN = $clog2(DEF_DATA_LENGTH_MAX);
  localparam int SEQ_W = 8;

  // Header layout from the LSB: dest, priority, length, src, seq[7:0]
  localparam int OFF_DEST = 0;
  localparam int OFF_PRI  = OFF_DEST + W_SEL;
  localparam int OFF_LEN  = OFF_PRI + W_PRI;
  localparam int OFF_SRC  = OFF_LEN + W_LEN;
  localparam int OFF_SEQ  = OFF_SRC + W_SEL;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'd0,
    MODE_CONT       = 2'd1,
    MODE_COUNTED    = 2'd2,
    MODE_SINGLE_ALT = 2'd3
  } send_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_GAP  = 2'd3
  } send_state_e;

endpackage

// File: rtl/send_pace_timer.sv
// send_pace_timer: counts cycles since the last header transfer and flags
// when a new header may be presented on the next cycle.
module send_pace_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [19:0] send_cycle,
  output logic        due
);

  logic [19:0] cnt_reg, cnt_next;
  logic [20:0] elapsed;

  // Count restarts at the sop transfer and saturates instead of wrapping
  always_comb begin
    cnt_next = cnt_reg;
    if (restart) begin
      cnt_next = 20'd1;
    end else if (cnt_reg != 20'hFFFFF) begin
      cnt_next = cnt_reg + 20'd1;
    end
  end

  // Elapsed count as of the next cycle; a same-cycle restart counts as zero so
  // header-only packets pace correctly
  always_comb begin
    elapsed = restart ? 21'd1 : ({1'b0, cnt_reg} + 21'd1);
    due     = (elapsed >= {1'b0, send_cycle});
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/send_gen.sv
// send_gen: packet source for one switch ingress port. Emits a header beat
// followed by payload beats on a sop/eop/vld bus with wr_rdy backpressure.
// Optional feature macro: SEND_DEST_SWEEP_EN (destination advances after
// every packet, skipping TX_PORT).
// The priority field port is named prio because priority is a reserved word.
module send_gen
  import send_pkg::*;
#(
  parameter int TX_PORT         = 0,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int PORT_NUB_TOTAL  = DEF_PORT_NUB_TOTAL,
  parameter int DATA_LENGTH_MAX = DEF_DATA_LENGTH_MAX,
  parameter int PRIORITY        = DEF_PRIORITY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic [15:0]                        pkt_count,
  input  logic [19:0]                        send_cycle,
  input  logic [$clog2(PORT_NUB_TOTAL)-1:0]  dest,
  input  logic [$clog2(PRIORITY)-1:0]        prio,
  input  logic [$clog2(DATA_LENGTH_MAX)-1:0] length,
  output logic                               ready,
  output logic                               done,
  input  logic                               wr_rdy,
  output logic                               wr_vld,
  output logic                               wr_sop,
  output logic                               wr_eop,
  output logic [DATA_WIDTH-1:0]              wr_data,
  output logic [15:0]                        pkt_sent
);

  localparam int SEL_W   = $clog2(PORT_NUB_TOTAL);
  localparam int PRI_W   = $clog2(PRIORITY);
  localparam int LEN_W   = $clog2(DATA_LENGTH_MAX);
  localparam int HDR_PRI = SEL_W;
  localparam int HDR_LEN = HDR_PRI + PRI_W;
  localparam int HDR_SRC = HDR_LEN + LEN_W;
  localparam int HDR_SEQ = HDR_SRC + SEL_W;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  send_state_e      state_reg, state_next;
  send_mode_e       mode_reg;
  logic [15:0]      remain_reg;
  logic [19:0]      cycle_reg;
  logic [SEL_W-1:0] dest_reg;
  logic [PRI_W-1:0] prio_reg;
  logic [LEN_W-1:0] len_reg, beat_reg;
  logic [SEQ_W-1:0] seq_reg;
  logic [15:0]      sent_reg;
  logic             done_reg, done_next, armed_reg;
  logic             launch, zero_run, beat_vld, last_beat;
  logic             xfer, sop_xfer, eop_xfer, carry_on, pace_due;
  logic [DATA_WIDTH-1:0] hdr_data, body_data;

`ifdef SEND_DEST_SWEEP_EN
  function automatic logic [SEL_W-1:0] dest_step(input logic [SEL_W-1:0] d);
    logic [SEL_W-1:0] n;
    n = (int'(d) + 1 >= PORT_NUB_TOTAL) ? '0 : d + SEL_W'(1);
    if (int'(n) == TX_PORT) begin
      n = (int'(n) + 1 >= PORT_NUB_TOTAL) ? '0 : n + SEL_W'(1);
    end
    return n;
  endfunction
`endif

  send_pace_timer u_pace (
    .clk        (clk),
    .rst        (rst),
    .restart    (sop_xfer),
    .send_cycle (cycle_reg),
    .due        (pace_due)
  );

  // Handshake qualifiers and the continue/stop decision used at eop
  always_comb begin
    launch    = (state_reg == ST_IDLE) && start && armed_reg;
    zero_run  = (mode == MODE_COUNTED) && (pkt_count == 16'd0);
    beat_vld  = (state_reg == ST_HEAD) || (state_reg == ST_BODY);
    last_beat = (state_reg == ST_HEAD) ? (len_reg == '0) : (beat_reg == len_reg - LEN_ONE);
    xfer      = beat_vld && wr_rdy;
    sop_xfer  = xfer && (state_reg == ST_HEAD);
    eop_xfer  = xfer && last_beat;
    case (mode_reg)
      MODE_CONT:    carry_on = start;
      MODE_COUNTED: carry_on = (remain_reg != 16'd1);
      default:      carry_on = 1'b0;
    endcase
  end

  // Next-state logic; done is raised on the transition back to IDLE
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          if (zero_run) done_next = 1'b1;
          else          state_next = ST_HEAD;
        end
      end
      ST_HEAD, ST_BODY: begin
        if (eop_xfer) begin
          if (!carry_on) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (pace_due) begin
            state_next = ST_HEAD;
          end else begin
            state_next = ST_GAP;
          end
        end else if (sop_xfer) begin
          state_next = ST_BODY;
        end
      end
      ST_GAP: begin
        if (pace_due) state_next = ST_HEAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and done pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Run configuration latch, beat index, sequence and packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg  <= 1'b0;
      mode_reg   <= MODE_SINGLE;
      remain_reg <= '0;
      cycle_reg  <= '0;
      dest_reg   <= '0;
      prio_reg   <= '0;
      len_reg    <= '0;
      beat_reg   <= '0;
      seq_reg    <= '0;
      sent_reg   <= '0;
    end else begin
      // A new run needs start seen low in IDLE first, so a held start never retriggers
      if ((state_reg == ST_IDLE) && !start) armed_reg <= 1'b1;
      else if (launch)                       armed_reg <= 1'b0;
      if (launch) begin
        mode_reg   <= send_mode_e'(mode);
        remain_reg <= pkt_count;
        cycle_reg  <= send_cycle;
        dest_reg   <= dest;
        prio_reg   <= prio;
        len_reg    <= length;
      end
      if (sop_xfer)                            beat_reg <= '0;
      else if (xfer && (state_reg == ST_BODY)) beat_reg <= beat_reg + LEN_ONE;
      if (eop_xfer) begin
        seq_reg    <= seq_reg + 8'd1;
        sent_reg   <= sent_reg + 16'd1;
        remain_reg <= remain_reg - 16'd1;
`ifdef SEND_DEST_SWEEP_EN
        dest_reg   <= dest_step(dest_reg);
`endif
      end
    end
  end

  // Beat formatting; outputs derive only from registers so they hold while stalled
  always_comb begin
    hdr_data = '0;
    hdr_data[0 +: SEL_W]       = dest_reg;
    hdr_data[HDR_PRI +: PRI_W] = prio_reg;
    hdr_data[HDR_LEN +: LEN_W] = len_reg;
    hdr_data[HDR_SRC +: SEL_W] = SEL_W'(TX_PORT);
    hdr_data[HDR_SEQ +: SEQ_W] = seq_reg;
    body_data = DATA_WIDTH'(beat_reg) ^ {seq_reg, {(DATA_WIDTH-SEQ_W){1'b0}}};
    ready    = (state_reg == ST_IDLE);
    done     = done_reg;
    wr_vld   = beat_vld;
    wr_sop   = (state_reg == ST_HEAD);
    wr_eop   = beat_vld && last_beat;
    wr_data  = (state_reg == ST_HEAD) ? hdr_data :
               (state_reg == ST_BODY) ? body_data : '0;
    pkt_sent = sent_reg;
  end

endmodule
